// File: rtl/barrelshifter16_pkg.sv
// Shared types and widths for the barrelshifter16 scheduler slice.
package barrelshifter16_pkg;

    localparam int DATA_W  = 16;
    localparam int COEFF_W = 3;

    typedef enum logic [1:0] {
        DIR_NOP0  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_NOP3  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENABLE = 3'd1,
        WRITE  = 3'd2,
        EXEC   = 3'd3,
        RESP   = 3'd4
    } sched_state_t;

    // Both 00 and 11 leave the operand untouched and bypass the shifter.
    function automatic logic is_nop(input logic [1:0] dir);
        return (dir == DIR_NOP0) || (dir == DIR_NOP3);
    endfunction

endpackage

// File: rtl/barrelshifter16_sched_if.sv
// Requester command bus and result bus of the shared-shifter scheduler.
interface barrelshifter16_sched_if #(
    parameter int NREQ = 4
);
    import barrelshifter16_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [DATA_W*NREQ-1:0]  req_data;
    logic [COEFF_W*NREQ-1:0] req_coeff;
    logic [2*NREQ-1:0]       req_dir;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        output req_valid, req_data, req_coeff, req_dir, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_coeff, req_dir, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/barrelshifter16_sched_arb.sv
// Round-robin arbiter: grants the first active request at or after the pointer.
module rr_arbiter16 #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic [IDW-1:0]  ptr
);
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW:0]   sum_s;
    logic [IDW:0]   nxt_s;
    logic [IDW-1:0] cand_s;
    logic           found_s;

    // Rotating priority search starting at the pointer, wrapping past NREQ-1.
    always_comb begin
        grant     = {NREQ{1'b0}};
        grant_idx = {IDW{1'b0}};
        found_s   = 1'b0;
        sum_s     = {(IDW+1){1'b0}};
        cand_s    = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum_s >= (IDW+1)'(NREQ)) begin
                sum_s = sum_s - (IDW+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDW-1:0];
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves just past the winner on an accepted grant.
    always_comb begin
        nxt_s = {1'b0, grant_idx} + {{IDW{1'b0}}, 1'b1};
        if (nxt_s >= (IDW+1)'(NREQ)) begin
            nxt_s = {(IDW+1){1'b0}};
        end else begin
            nxt_s = nxt_s;
        end
        ptr_d = advance ? nxt_s[IDW-1:0] : ptr_q;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= {IDW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/barrelshifter16_sched.sv
// Round-robin scheduler sharing one barrelshifter16 rotate unit between NREQ requesters.
module barrelshifter16_sched
    import barrelshifter16_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic                   aclk,
    input  logic                   areset,
    barrelshifter16_sched_if.slave bus,
    output logic                   busy,
    output logic                   sh_enable,
    output logic                   sh_write,
    output logic [1:0]             sh_direction,
    output logic [DATA_W-1:0]      sh_input,
    output logic [COEFF_W-1:0]     sh_coeff,
    input  logic [DATA_W-1:0]      sh_result
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WAIT_CYC + 1) + 1;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_ENABLE = ENABLE;
    localparam logic [2:0] ST_WRITE  = WRITE;
    localparam logic [2:0] ST_EXEC   = EXEC;
    localparam logic [2:0] ST_RESP   = RESP;

    localparam logic [CW-1:0] WRITE_LAST = CW'(1);
    localparam logic [CW-1:0] EXEC_LAST  = CW'(WAIT_CYC - 1);

    logic [2:0]         state_q,        state_d;
    logic [CW-1:0]      cnt_q,          cnt_d;
    logic [DATA_W-1:0]  op_data_q,      op_data_d;
    logic [COEFF_W-1:0] op_coeff_q,     op_coeff_d;
    logic [1:0]         op_dir_q,       op_dir_d;
    logic [IDW-1:0]     op_id_q,        op_id_d;
    logic               rsp_valid_q,    rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q,     rsp_data_d;
    logic [IDW-1:0]     rsp_id_q,       rsp_id_d;
    logic               busy_q,         busy_d;
    logic               sh_enable_q,    sh_enable_d;
    logic               sh_write_q,     sh_write_d;
    logic [DATA_W-1:0]  sh_input_q,     sh_input_d;
    logic [COEFF_W-1:0] sh_coeff_q,     sh_coeff_d;
    logic [1:0]         sh_direction_q, sh_direction_d;

    logic [NREQ-1:0]    grant_s;
    logic [NREQ-1:0]    ready_s;
    logic [IDW-1:0]     gidx_s;
    logic [IDW-1:0]     ptr_s;
    logic               advance_s;
    logic               load_ops_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic [COEFF_W-1:0] sel_coeff_s;
    logic [1:0]         sel_dir_s;

    rr_arbiter16 #(.NREQ(NREQ)) u_arb (
        .clk       (aclk),
        .rst       (areset),
        .req       (bus.req_valid),
        .advance   (advance_s),
        .grant     (grant_s),
        .grant_idx (gidx_s),
        .ptr       (ptr_s)
    );

    // Grants are only offered while idle; an offered grant is always a handshake.
    always_comb begin
        ready_s   = grant_s & {NREQ{state_q == ST_IDLE}};
        advance_s = |ready_s;
    end

    // One-hot grant selects the winning requester's command fields.
    always_comb begin
        sel_data_s  = {DATA_W{1'b0}};
        sel_coeff_s = {COEFF_W{1'b0}};
        sel_dir_s   = 2'b00;
        for (int k = 0; k < NREQ; k++) begin
            sel_data_s  |= {DATA_W{grant_s[k]}}  & bus.req_data[k*DATA_W +: DATA_W];
            sel_coeff_s |= {COEFF_W{grant_s[k]}} & bus.req_coeff[k*COEFF_W +: COEFF_W];
            sel_dir_s   |= {2{grant_s[k]}}       & bus.req_dir[k*2 +: 2];
        end
    end

    // Command sequencer; cnt_q times the two WRITE cycles and the EXEC wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (advance_s) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = is_nop(sel_dir_s) ? ST_RESP : ST_ENABLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENABLE: begin
                state_d = ST_WRITE;
                cnt_d   = {CW{1'b0}};
            end
            ST_WRITE: begin
                if (cnt_q == WRITE_LAST) begin
                    state_d = ST_EXEC;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Operand latch, result capture and shifter drive values.
    always_comb begin
        op_data_d  = advance_s ? sel_data_s  : op_data_q;
        op_coeff_d = advance_s ? sel_coeff_s : op_coeff_q;
        op_dir_d   = advance_s ? sel_dir_s   : op_dir_q;
        op_id_d    = advance_s ? gidx_s      : op_id_q;

        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (advance_s && is_nop(sel_dir_s)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sel_data_s;
            rsp_id_d    = gidx_s;
        end else if ((state_q == ST_EXEC) && (cnt_q == EXEC_LAST)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sh_result;
            rsp_id_d    = op_id_q;
        end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end

        busy_d      = (state_d != ST_IDLE);
        sh_enable_d = (state_d == ST_ENABLE) || (state_d == ST_WRITE) || (state_d == ST_EXEC);
        sh_write_d  = (state_d == ST_WRITE);

        // Operands appear with the first WRITE cycle and hold until the next command.
        load_ops_s     = (state_q == ST_ENABLE);
        sh_input_d     = load_ops_s ? op_data_q  : sh_input_q;
        sh_coeff_d     = load_ops_s ? op_coeff_q : sh_coeff_q;
        sh_direction_d = load_ops_s ? op_dir_q   : sh_direction_q;
    end

    // State and output registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {CW{1'b0}};
            op_data_q      <= {DATA_W{1'b0}};
            op_coeff_q     <= {COEFF_W{1'b0}};
            op_dir_q       <= 2'b00;
            op_id_q        <= {IDW{1'b0}};
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= {DATA_W{1'b0}};
            rsp_id_q       <= {IDW{1'b0}};
            busy_q         <= 1'b0;
            sh_enable_q    <= 1'b0;
            sh_write_q     <= 1'b0;
            sh_input_q     <= {DATA_W{1'b0}};
            sh_coeff_q     <= {COEFF_W{1'b0}};
            sh_direction_q <= 2'b00;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_data_q      <= op_data_d;
            op_coeff_q     <= op_coeff_d;
            op_dir_q       <= op_dir_d;
            op_id_q        <= op_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_id_q       <= rsp_id_d;
            busy_q         <= busy_d;
            sh_enable_q    <= sh_enable_d;
            sh_write_q     <= sh_write_d;
            sh_input_q     <= sh_input_d;
            sh_coeff_q     <= sh_coeff_d;
            sh_direction_q <= sh_direction_d;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = busy_q;
    assign sh_enable     = sh_enable_q;
    assign sh_write      = sh_write_q;
    assign sh_input      = sh_input_q;
    assign sh_coeff      = sh_coeff_q;
    assign sh_direction  = sh_direction_q;

endmodule

// File: tb/tb_barrelshifter16_sched.sv
// Self-checking bench for barrelshifter16_sched with a behavioural shifter and scoreboard.
module tb_barrelshifter16_sched;
    localparam int NREQ     = 4;
    localparam int WAIT_CYC = 2;
    localparam int LAT_SH   = 3 + WAIT_CYC + 1;

    logic        aclk   = 1'b0;
    logic        areset = 1'b1;
    logic        busy;
    logic        sh_enable;
    logic        sh_write;
    logic [1:0]  sh_direction;
    logic [15:0] sh_input;
    logic [2:0]  sh_coeff;
    logic [15:0] sh_result;
    logic [15:0] shf_q = 16'h0000;

    always #5 aclk = ~aclk;

    barrelshifter16_sched_if #(.NREQ(NREQ)) bus ();

    barrelshifter16_sched #(.NREQ(NREQ), .WAIT_CYC(WAIT_CYC)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .bus          (bus),
        .busy         (busy),
        .sh_enable    (sh_enable),
        .sh_write     (sh_write),
        .sh_direction (sh_direction),
        .sh_input     (sh_input),
        .sh_coeff     (sh_coeff),
        .sh_result    (sh_result)
    );

    // Bit-level stand-in for the shared rotate unit.
    function automatic logic [15:0] bit_rot(input logic [15:0] d, input logic [2:0] c, input logic [1:0] dir);
        logic [15:0] o;
        o = d;
        for (int i = 0; i < 16; i++) begin
            if (dir == 2'b10) o[(i + int'(c)) % 16] = d[i];
            else if (dir == 2'b01) o[i] = d[(i + int'(c)) % 16];
        end
        return o;
    endfunction

    always @(posedge aclk) begin
        if (sh_enable && sh_write) shf_q <= bit_rot(sh_input, sh_coeff, sh_direction);
    end
    assign sh_result = shf_q;

    // Reference result from plain arithmetic.
    function automatic int model_rot(int d, int c, int dir);
        if (dir == 2) return ((d << c) | (d >> (16 - c))) & 32'hFFFF;
        if (dir == 1) return ((d >> c) | (d << (16 - c))) & 32'hFFFF;
        return d;
    endfunction

    int n_chk = 0;
    int n_fail = 0;
    int onehot_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int id;
        int data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          id;
        logic [15:0] data;
        logic [2:0]  coeff;
        logic [1:0]  dir;
        logic [15:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[8];

    // Scoreboard: predicts grant order and results, checks every delivered response.
    initial begin : monitor
        logic [NREQ-1:0] hs;
        int m_ptr, eg, g, j;
        exp_t e, p;
        m_ptr = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                sbq.delete();
                m_ptr = 0;
            end else begin
                hs = bus.req_valid & bus.req_ready;
                if ($countones(bus.req_ready) > 1) onehot_err++;
                if (hs != '0) begin
                    eg = -1;
                    g  = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        j = (m_ptr + k) % NREQ;
                        if (eg < 0 && bus.req_valid[j]) eg = j;
                        if (g < 0 && hs[k]) g = k;
                    end
                    check("grant_index", g, eg);
                    e.id   = g;
                    e.data = model_rot(int'(bus.req_data[g*16 +: 16]), int'(bus.req_coeff[g*3 +: 3]),
                                       int'(bus.req_dir[g*2 +: 2]));
                    sbq.push_back(e);
                    m_ptr = (g + 1) % NREQ;
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sbq.size() == 0) begin
                        check("rsp_unexpected", sbq.size(), 1);
                    end else begin
                        p = sbq.pop_front();
                        check("sb_rsp_id", int'(bus.rsp_id), p.id);
                        check("sb_rsp_data", int'(bus.rsp_data), p.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
    endtask

    task automatic set_req(input int id, input logic [15:0] d, input logic [2:0] c, input logic [1:0] dir);
        bus.req_data[id*16 +: 16] = d;
        bus.req_coeff[id*3 +: 3]  = c;
        bus.req_dir[id*2 +: 2]    = dir;
        bus.req_valid[id]         = 1'b1;
    endtask

    task automatic wait_grant(input int id, input string name);
        int t;
        t = 0;
        while (!bus.req_ready[id] && t < 40) begin
            tick();
            #1;
            t++;
        end
        check(name, int'(bus.req_ready[id]), 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        check("drain_empty", sbq.size(), 0);
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int lat, en_cnt, wr_cnt;
        bus.rsp_ready = 1'b1;
        set_req(v.id, v.data, v.coeff, v.dir);
        #1;
        wait_grant(v.id, "vec_grant");
        tick();
        bus.req_valid[v.id] = 1'b0;
        #1;
        lat    = 1;
        en_cnt = int'(sh_enable);
        wr_cnt = int'(sh_write);
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            #1;
            lat++;
            en_cnt += int'(sh_enable);
            wr_cnt += int'(sh_write);
        end
        check("vec_rsp_valid", int'(bus.rsp_valid), 1);
        check("vec_latency", lat, v.lat);
        check("vec_rsp_data", int'(bus.rsp_data), int'(v.exp));
        check("vec_rsp_id", int'(bus.rsp_id), v.id);
        check("vec_sh_enable_cycles", en_cnt, (v.lat == 1) ? 0 : 3 + WAIT_CYC);
        check("vec_sh_write_cycles", wr_cnt, (v.lat == 1) ? 0 : 2);
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int order[$];
        int t, st_err, rdy_err;
        logic [15:0] hold_d;
        logic [1:0]  hold_id;

        vecs[0] = '{0, 16'h8001, 3'd1, 2'b10, 16'h0003, LAT_SH};
        vecs[1] = '{2, 16'h0001, 3'd1, 2'b01, 16'h8000, LAT_SH};
        vecs[2] = '{2, 16'h1234, 3'd0, 2'b10, 16'h1234, LAT_SH};
        vecs[3] = '{1, 16'hBEEF, 3'd3, 2'b00, 16'hBEEF, 1};
        vecs[4] = '{3, 16'h5A5A, 3'd2, 2'b11, 16'h5A5A, 1};
        vecs[5] = '{1, 16'hF00F, 3'd7, 2'b01, 16'h1FE0, LAT_SH};
        vecs[6] = '{3, 16'h00FF, 3'd4, 2'b10, 16'h0FF0, LAT_SH};
        vecs[7] = '{0, 16'h8000, 3'd7, 2'b10, 16'h0040, LAT_SH};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_coeff = '0;
        bus.req_dir   = '0;
        bus.rsp_ready = 1'b0;
        areset        = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
        #1;
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_rsp_id", int'(bus.rsp_id), 0);
        check("rst_rsp_data", int'(bus.rsp_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sh_ctrl", int'({sh_enable, sh_write, sh_direction, sh_coeff}), 0);
        check("rst_sh_input", int'(sh_input), 0);

        // All requesters continuously valid: rotation must start at 0.
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 16'h1000 * (i + 1) + 16'(i), 3'(i + 1), 2'b10);
        #1;
        t = 0;
        while (order.size() < 5 && t < 200) begin
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) order.push_back(i);
            tick();
            #1;
            t++;
        end
        clear_reqs();
        check("rr_grant_count", order.size(), 5);
        for (int k = 0; k < order.size(); k++) check("rr_order", order[k], k % NREQ);
        drain();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Result held under backpressure while another requester waits.
        bus.rsp_ready = 1'b0;
        set_req(0, 16'hA5A5, 3'd3, 2'b10);
        #1;
        wait_grant(0, "bp_first_grant");
        tick();
        bus.req_valid[0] = 1'b0;
        t = 0;
        while (!bus.rsp_valid && t < 20) begin
            tick();
            t++;
        end
        set_req(3, 16'h0F0F, 3'd2, 2'b01);
        #1;
        check("bp_rsp_valid", int'(bus.rsp_valid), 1);
        hold_d  = bus.rsp_data;
        hold_id = bus.rsp_id;
        check("bp_rsp_data", int'(hold_d), 16'h2D2D);
        st_err  = 0;
        rdy_err = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            #1;
            if (!bus.rsp_valid || bus.rsp_data != hold_d || bus.rsp_id != hold_id) st_err++;
            if (bus.req_ready[3]) rdy_err++;
        end
        check("bp_stable_errors", st_err, 0);
        check("bp_ready3_errors", rdy_err, 0);
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        check("bp_grant_next_idle", int'(bus.req_ready), 4'b1000);
        tick();
        clear_reqs();
        drain();

        // Reset during EXEC aborts the command and clears the pointer.
        set_req(1, 16'h1357, 3'd5, 2'b10);
        #1;
        wait_grant(1, "rst_exec_grant");
        tick();
        bus.req_valid[1] = 1'b0;
        repeat (3) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        #1;
        check("rstx_rsp_valid", int'(bus.rsp_valid), 0);
        check("rstx_sh_enable", int'(sh_enable), 0);
        check("rstx_busy", int'(busy), 0);
        set_req(0, 16'h00F0, 3'd4, 2'b01);
        set_req(2, 16'h0F00, 3'd1, 2'b10);
        #1;
        check("rstx_ptr_zero_grant", int'(bus.req_ready), 4'b0001);
        tick();
        clear_reqs();
        drain();

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 600; c++) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                bus.req_data[i*16 +: 16] = 16'($urandom);
                bus.req_coeff[i*3 +: 3]  = 3'($urandom_range(0, 7));
                bus.req_dir[i*2 +: 2]    = 2'($urandom_range(0, 3));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        clear_reqs();
        bus.rsp_ready = 1'b1;
        drain();
        check("onehot_violations", onehot_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
